// File: rtl/mmcm_ps_stepper.sv
// MMCM dynamic phase-shift stepper: deadband decision, psen/psdone handshake,
// settle hold-off, saturating step position, lock and timeout status.
module mmcm_ps_stepper #(
    parameter int WIDTH          = 32,
    parameter int DEADBAND       = 4096,
    parameter int SETTLE_CYCLES  = 64,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_STEPS      = 4096,
    parameter int LOCK_COUNT     = 16
) (
    input  logic             clk,
    input  logic             reset_in_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] err_in,
    output logic             psen,
    output logic             psincdec,
    input  logic             psdone,
    output logic [15:0]      position,
    output logic             locked,
    output logic             at_limit,
    output logic             timeout_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int LW = $clog2(LOCK_COUNT + 1);

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] S_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [LW-1:0] L_MAX  = LW'(LOCK_COUNT);
    localparam logic [LW-1:0] L_PRE  = LW'(LOCK_COUNT - 1);

    localparam logic signed [WIDTH-1:0] DB_HI = WIDTH'(DEADBAND);
    localparam logic signed [WIDTH-1:0] DB_LO = -DB_HI;
    localparam logic signed [15:0]      POS_HI = 16'(MAX_STEPS);
    localparam logic signed [15:0]      POS_LO = -POS_HI;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_DONE,
        SETTLE
    } state_t;

    state_t             state_q;
    logic [TW-1:0]      tcnt_q;
    logic [SW-1:0]      scnt_q;
    logic [LW-1:0]      lcnt_q;
    logic               psen_q;
    logic               inc_q;
    logic               locked_q;
    logic               at_limit_q;
    logic               timeout_q;
    logic signed [15:0] pos_q;
    logic signed [15:0] pos_d;

    logic want_up;
    logic want_dn;
    logic blocked;

    always_comb begin
        want_up = $signed(err_in) > DB_HI;
        want_dn = $signed(err_in) < DB_LO;
        blocked = (want_up && (pos_q >= POS_HI)) ||
                  (want_dn && (pos_q <= POS_LO));
        pos_d   = inc_q ? pos_q + 16'sd1 : pos_q - 16'sd1;
    end

    always_ff @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            state_q    <= IDLE;
            tcnt_q     <= '0;
            scnt_q     <= '0;
            lcnt_q     <= '0;
            psen_q     <= 1'b0;
            inc_q      <= 1'b0;
            locked_q   <= 1'b0;
            at_limit_q <= 1'b0;
            timeout_q  <= 1'b0;
            pos_q      <= '0;
        end else begin
            psen_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!enable) begin
                        lcnt_q   <= '0;
                        locked_q <= 1'b0;
                    end else if (want_up || want_dn) begin
                        lcnt_q   <= '0;
                        locked_q <= 1'b0;
                        if (blocked) begin
                            at_limit_q <= 1'b1;
                        end else begin
                            at_limit_q <= 1'b0;
                            inc_q      <= want_up;
                            psen_q     <= 1'b1;
                            state_q    <= REQ;
                        end
                    end else begin
                        at_limit_q <= 1'b0;
                        if (lcnt_q != L_MAX)
                            lcnt_q <= lcnt_q + LW'(1);
                        locked_q <= (lcnt_q >= L_PRE);
                    end
                end
                REQ: begin
                    tcnt_q  <= '0;
                    state_q <= WAIT_DONE;
                end
                // psdone takes priority over the timeout terminal count
                WAIT_DONE: begin
                    if (psdone) begin
                        pos_q   <= pos_d;
                        scnt_q  <= '0;
                        state_q <= SETTLE;
                    end else if (tcnt_q == T_LAST) begin
                        timeout_q <= 1'b1;
                        scnt_q    <= '0;
                        state_q   <= SETTLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                SETTLE: begin
                    if (scnt_q == S_LAST)
                        state_q <= IDLE;
                    else
                        scnt_q <= scnt_q + SW'(1);
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign psen        = psen_q;
    assign psincdec    = inc_q;
    assign position    = pos_q;
    assign locked      = locked_q;
    assign at_limit    = at_limit_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_mmcm_ps_stepper.sv
// Randomized bench for mmcm_ps_stepper: transaction-timeline reference model,
// per-cycle output compare, and directed literal checks.
module tb_mmcm_ps_stepper;

    localparam int W  = 32;
    localparam int DB = 4096;
    localparam int ST = 8;
    localparam int TO = 40;
    localparam int MX = 6;
    localparam int LK = 5;

    logic          clk = 1'b0;
    logic          reset_in_n = 1'b0;
    logic          enable = 1'b0;
    logic [W-1:0]  err_in = '0;
    logic          psen;
    logic          psincdec;
    logic          psdone = 1'b0;
    logic [15:0]   position;
    logic          locked;
    logic          at_limit;
    logic          timeout_err;

    mmcm_ps_stepper #(
        .WIDTH(W), .DEADBAND(DB), .SETTLE_CYCLES(ST),
        .TIMEOUT_CYCLES(TO), .MAX_STEPS(MX), .LOCK_COUNT(LK)
    ) dut (
        .clk(clk), .reset_in_n(reset_in_n), .enable(enable),
        .err_in(err_in), .psen(psen), .psincdec(psincdec),
        .psdone(psdone), .position(position), .locked(locked),
        .at_limit(at_limit), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc = 0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, ncyc, got, exp);
        end
    endtask

    // Reference model: a transaction is a timeline of edge indices
    // (request edge, end-of-wait edge); decisions only when no transaction is open.
    int     m_n, t_req, t_end, m_pos, m_cnt;
    bit     m_busy, m_psen, m_inc, m_lock, m_lim, m_to, m_up;
    longint m_e;

    always @(posedge clk or negedge reset_in_n) begin
        if (!reset_in_n) begin
            m_n = 0; t_req = 0; t_end = -1; m_pos = 0; m_cnt = 0;
            m_busy = 0; m_psen = 0; m_inc = 0; m_lock = 0; m_lim = 0; m_to = 0;
        end else begin
            m_n++;
            m_psen = 0;
            m_e = longint'($signed(err_in));
            if (!m_busy) begin
                if (!enable) begin
                    m_cnt = 0; m_lock = 0;
                end else if (m_e > DB || m_e < -DB) begin
                    m_up = (m_e > DB);
                    m_cnt = 0; m_lock = 0;
                    if ((m_up && m_pos >= MX) || (!m_up && m_pos <= -MX)) begin
                        m_lim = 1;
                    end else begin
                        m_lim = 0; m_inc = m_up; m_psen = 1;
                        m_busy = 1; t_req = m_n + 1; t_end = -1;
                    end
                end else begin
                    m_lim = 0;
                    if (m_cnt < LK) m_cnt++;
                    m_lock = (m_cnt >= LK);
                end
            end else if (m_n > t_req) begin
                if (t_end < 0) begin
                    if (psdone) begin
                        m_pos += m_inc ? 1 : -1;
                        t_end = m_n;
                    end else if (m_n - t_req == TO) begin
                        m_to = 1;
                        t_end = m_n;
                    end
                end else if (m_n - t_end == ST) begin
                    m_busy = 0;
                end
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        ncyc++;
        if (chk_on && reset_in_n) begin
            chk("psen", int'(psen), int'(m_psen));
            chk("psincdec", int'(psincdec), int'(m_inc));
            chk("position", int'($signed(position)), m_pos);
            chk("locked", int'(locked), int'(m_lock));
            chk("at_limit", int'(at_limit), int'(m_lim));
            chk("timeout_err", int'(timeout_err), int'(m_to));
        end
    end

    // MMCM responder: psdone a programmable number of cycles after psen
    int cd = -1;
    int delay = 12;
    bit resp_none = 0;
    bit rnd_mode = 0;
    bit spur_on = 0;
    always @(negedge clk) begin
        if (!reset_in_n) begin
            cd = -1;
            psdone = 0;
        end else begin
            psdone = 0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    psdone = 1;
                    cd = -1;
                end
            end else if (spur_on && $urandom_range(0, 15) == 0) begin
                psdone = 1;
            end
            if (psen) begin
                if (rnd_mode) begin
                    resp_none = ($urandom_range(0, 7) == 0);
                    delay = $urandom_range(1, 8);
                end
                cd = resp_none ? -1 : delay;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_psen(input int maxc, output int t);
        t = -1;
        for (int k = 0; k < maxc; k++) begin
            cyc(1);
            if (psen) begin
                t = ncyc;
                break;
            end
        end
        checks++;
        if (t < 0) begin
            errors++;
            $display("FAIL wait_psen: got no psen, expected one within %0d cycles", maxc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_psen"}, int'(psen), 0);
        chk({tag, "_psincdec"}, int'(psincdec), 0);
        chk({tag, "_position"}, int'($signed(position)), 0);
        chk({tag, "_locked"}, int'(locked), 0);
        chk({tag, "_at_limit"}, int'(at_limit), 0);
        chk({tag, "_timeout"}, int'(timeout_err), 0);
    endtask

    int t0, t1, sq;
    int v;

    initial begin
        #1;
        chk_all_zero("reset");
        cyc(3);
        reset_in_n = 1;
        chk_on = 1;
        cyc(2);

        // single up step, psdone after 12 cycles, settle spacing
        delay = 12;
        err_in = 32'(10000);
        enable = 1;
        wait_psen(10, t0);
        chk("t1_psincdec", int'(psincdec), 1);
        wait_psen(100, t1);
        chk("t1_gap", t1 - t0, 12 + ST + 2);
        chk("t1_position", int'($signed(position)), 1);
        enable = 0;
        err_in = '0;
        cyc(40);

        // repeated decrements to the negative limit
        rnd_mode = 1;
        err_in = -32'sd10000;
        enable = 1;
        cyc(400);
        rnd_mode = 0;
        resp_none = 0;
        chk("t2_position", int'($signed(position)), -MX);
        chk("t2_at_limit", int'(at_limit), 1);

        // deadband edge and lock
        enable = 0;
        cyc(1);
        err_in = 32'(DB);
        enable = 1;
        cyc(LK - 1);
        chk("t3_locked_early", int'(locked), 0);
        cyc(1);
        chk("t3_locked", int'(locked), 1);
        chk("t3_at_limit", int'(at_limit), 0);

        // just outside band: step issued, then timeouts with silent MMCM
        resp_none = 1;
        err_in = 32'(DB + 1);
        wait_psen(5, t0);
        chk("t3_unlock", int'(locked), 0);
        wait_psen(TO + ST + 10, t1);
        chk("t4_timeout", int'(timeout_err), 1);
        chk("t4_position", int'($signed(position)), -MX);
        chk("t4_resume_gap", t1 - t0, TO + ST + 2);
        err_in = '0;
        cyc(TO + ST + 10);
        resp_none = 0;

        // enable dropped mid-handshake, then reset mid-settle
        delay = 10;
        err_in = 32'(10000);
        enable = 1;
        wait_psen(5, t0);
        cyc(3);
        enable = 0;
        cyc(30);
        chk("t5_position", int'($signed(position)), -MX + 1);
        delay = 3;
        enable = 1;
        wait_psen(5, t0);
        cyc(6);
        chk("t5_pre_reset_pos", int'($signed(position)), -MX + 2);
        #2;
        reset_in_n = 0;
        #1;
        chk_all_zero("t5_reset");
        @(negedge clk);
        reset_in_n = 1;
        cyc(2);

        // square-wave error with noise, random enable, delays, spurious psdone
        rnd_mode = 1;
        spur_on = 1;
        enable = 1;
        sq = 0;
        for (int i = 0; i < 3000; i++) begin
            sq++;
            v = sq[6] ? 16384 : -16384;
            if ($urandom_range(0, 9) == 0)
                v = int'($urandom_range(0, 2 * DB)) - DB;
            else
                v = v + int'($urandom_range(0, 2000)) - 1000;
            err_in = 32'(v);
            if ($urandom_range(0, 99) == 0)
                enable = ~enable;
            cyc(1);
        end
        v = int'($signed(position));
        chk("t6_pos_bounded", int'(v >= -MX && v <= MX), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
